// File: rtl/vertex_unpacker_pkg.sv
// vertex_unpacker_pkg
//   Shared definitions for the vertex unpacker:
//     - FSM state encoding (IDLE / FETCH / OUT, 2-bit)
//     - FIFO word slot indices within one vertex (X, Y, Z, W)
//     - ONE_F: IEEE-754 single 1.0, used as w when no w word is streamed
//     - WORDS_PER_VTX / LAST_SLOT: words popped per vertex
//   Configuration macro: VTX_W_EN (defined -> 4 words per vertex incl. w,
//   undefined -> 3 words per vertex, w is the constant ONE_F).
package vertex_unpacker_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_FETCH = 2'd1;
  localparam state_t ST_OUT   = 2'd2;

  localparam logic [1:0] SLOT_X = 2'd0;
  localparam logic [1:0] SLOT_Y = 2'd1;
  localparam logic [1:0] SLOT_Z = 2'd2;
  localparam logic [1:0] SLOT_W = 2'd3;

  localparam logic [31:0] ONE_F = 32'h3F80_0000;

`ifdef VTX_W_EN
  localparam int unsigned WORDS_PER_VTX = 4;
`else
  localparam int unsigned WORDS_PER_VTX = 3;
`endif

  localparam logic [1:0] LAST_SLOT = 2'(WORDS_PER_VTX - 1);

endpackage

// File: rtl/vertex_unpacker.sv
// vertex_unpacker
//   Pops 32-bit words from a show-ahead FIFO, packs them into vertex records
//   (x, y, z[, w]) and hands each record to the transform engine. Vertices
//   are counted into triangles; the job ends after i_num_tri triangles.
//
//   Handshakes:
//     FIFO side : a word is consumed in any cycle where o_fifo_renable=1
//                 (only in FETCH, only when i_fifo_empty=0).
//     Vertex side: a record transfers in a cycle where o_vtx_valid=1 and
//                 i_vtx_ack=1; while valid and not acked all o_vtx_* hold.
//                 i_vtx_ack is ignored when o_vtx_valid=0.
//
//   Ports:
//     clk, rst_x                 clock, async active-low reset
//     i_start, i_num_tri         job start pulse and triangle count
//     i_fifo_dt, i_fifo_empty    FIFO head word / empty flag
//     o_fifo_renable             FIFO pop (combinational)
//     o_vtx_valid, i_vtx_ack     vertex record handshake
//     o_vtx_x/y/z/w              vertex components
//     o_vtx_idx, o_vtx_last      vertex index in triangle, final vertex flag
//     o_busy, o_done             job in progress, one-cycle end pulse
//     o_tri_count                triangles fully acknowledged
//
//   Configuration macro: VTX_W_EN (w streamed from FIFO when defined,
//   otherwise w is the constant 1.0f and no w register exists).
module vertex_unpacker
  import vertex_unpacker_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_x,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_num_tri,
  input  logic [31:0]      i_fifo_dt,
  input  logic             i_fifo_empty,
  output logic             o_fifo_renable,
  output logic             o_vtx_valid,
  output logic [31:0]      o_vtx_x,
  output logic [31:0]      o_vtx_y,
  output logic [31:0]      o_vtx_z,
  output logic [31:0]      o_vtx_w,
  output logic [1:0]       o_vtx_idx,
  output logic             o_vtx_last,
  input  logic             i_vtx_ack,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_tri_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [1:0]       word_idx_q, word_idx_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [1:0]       vtx_idx_q, vtx_idx_d;
  logic [CNT_W-1:0] tri_count_q, tri_count_d;
  logic             done_q, done_d;
  logic [31:0]      x_q, x_d;
  logic [31:0]      y_q, y_d;
  logic [31:0]      z_q, z_d;
`ifdef VTX_W_EN
  logic [31:0]      w_q, w_d;
`endif

  logic pop;
  logic last_vtx;

  assign pop            = (state_q == ST_FETCH) && !i_fifo_empty;
  // remaining counts triangles still to finish after the current one.
  assign last_vtx       = (vtx_idx_q == 2'd2) && (remaining_q == '0);

  assign o_fifo_renable = pop;
  assign o_vtx_valid    = (state_q == ST_OUT);
  assign o_busy         = (state_q != ST_IDLE);
  assign o_done         = done_q;
  assign o_vtx_idx      = vtx_idx_q;
  assign o_vtx_last     = last_vtx;
  assign o_tri_count    = tri_count_q;
  assign o_vtx_x        = x_q;
  assign o_vtx_y        = y_q;
  assign o_vtx_z        = z_q;
`ifdef VTX_W_EN
  assign o_vtx_w        = w_q;
`else
  assign o_vtx_w        = ONE_F;
`endif

  always_comb begin
    state_d     = state_q;
    word_idx_d  = word_idx_q;
    remaining_d = remaining_q;
    vtx_idx_d   = vtx_idx_q;
    tri_count_d = tri_count_q;
    done_d      = 1'b0;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
`ifdef VTX_W_EN
    w_d         = w_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          tri_count_d = '0;
          if (i_num_tri != '0) begin
            remaining_d = i_num_tri - CNT_ONE;
            word_idx_d  = '0;
            vtx_idx_d   = '0;
            state_d     = ST_FETCH;
          end else begin
            // Empty job: finish immediately without ever going busy.
            done_d = 1'b1;
          end
        end
      end

      ST_FETCH: begin
        if (pop) begin
          case (word_idx_q)
            SLOT_X:  x_d = i_fifo_dt;
            SLOT_Y:  y_d = i_fifo_dt;
            SLOT_Z:  z_d = i_fifo_dt;
`ifdef VTX_W_EN
            SLOT_W:  w_d = i_fifo_dt;
`endif
            default: ;
          endcase
          if (word_idx_q == LAST_SLOT) begin
            state_d = ST_OUT;
          end else begin
            word_idx_d = word_idx_q + 2'd1;
          end
        end
      end

      ST_OUT: begin
        if (i_vtx_ack) begin
          word_idx_d = '0;
          state_d    = ST_FETCH;
          if (vtx_idx_q == 2'd2) begin
            tri_count_d = tri_count_q + CNT_ONE;
            vtx_idx_d   = '0;
            if (last_vtx) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              remaining_d = remaining_q - CNT_ONE;
            end
          end else begin
            vtx_idx_d = vtx_idx_q + 2'd1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      state_q     <= ST_IDLE;
      word_idx_q  <= '0;
      remaining_q <= '0;
      vtx_idx_q   <= '0;
      tri_count_q <= '0;
      done_q      <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
`ifdef VTX_W_EN
      w_q         <= '0;
`endif
    end else begin
      state_q     <= state_d;
      word_idx_q  <= word_idx_d;
      remaining_q <= remaining_d;
      vtx_idx_q   <= vtx_idx_d;
      tri_count_q <= tri_count_d;
      done_q      <= done_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
`ifdef VTX_W_EN
      w_q         <= w_d;
`endif
    end
  end

endmodule

// File: tb/tb_vertex_unpacker.sv
// tb_vertex_unpacker
//   Directed and randomized jobs against a queue-based FIFO model and a
//   reference that slices the pushed word stream into expected records.
module tb_vertex_unpacker;

  localparam int CNT_W = 16;
`ifdef VTX_W_EN
  localparam int NW = 4;
  localparam logic [31:0] RST_W = 32'h0;
`else
  localparam int NW = 3;
  localparam logic [31:0] RST_W = 32'h3F80_0000;
`endif
  localparam logic [31:0] ONE = 32'h3F80_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_x = 1'b0;
  always #5 clk = ~clk;

  logic             i_start = 1'b0;
  logic [CNT_W-1:0] i_num_tri = '0;
  logic [31:0]      i_fifo_dt = 32'hDEAD_BEEF;
  logic             i_fifo_empty = 1'b1;
  logic             o_fifo_renable;
  logic             o_vtx_valid;
  logic [31:0]      o_vtx_x, o_vtx_y, o_vtx_z, o_vtx_w;
  logic [1:0]       o_vtx_idx;
  logic             o_vtx_last;
  logic             i_vtx_ack = 1'b1;
  logic             o_busy;
  logic             o_done;
  logic [CNT_W-1:0] o_tri_count;

  vertex_unpacker #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_x(rst_x), .i_start(i_start), .i_num_tri(i_num_tri),
    .i_fifo_dt(i_fifo_dt), .i_fifo_empty(i_fifo_empty),
    .o_fifo_renable(o_fifo_renable), .o_vtx_valid(o_vtx_valid),
    .o_vtx_x(o_vtx_x), .o_vtx_y(o_vtx_y), .o_vtx_z(o_vtx_z), .o_vtx_w(o_vtx_w),
    .o_vtx_idx(o_vtx_idx), .o_vtx_last(o_vtx_last), .i_vtx_ack(i_vtx_ack),
    .o_busy(o_busy), .o_done(o_done), .o_tri_count(o_tri_count)
  );

  // ---------------- bookkeeping ----------------
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int pops = 0;
  int bad_pop = 0;
  int unstable = 0;
  int waits = 0;
  logic [31:0]  fifo[$];
  logic [130:0] got_q[$];
  int           acc_cyc[$];
  logic [130:0] prev_rec = '0;
  bit           prev_wait = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void refresh();
    i_fifo_empty = (fifo.size() == 0);
    i_fifo_dt    = (fifo.size() == 0) ? 32'hDEAD_BEEF : fifo[0];
  endfunction

  task automatic push_word(input logic [31:0] v);
    fifo.push_back(v);
    refresh();
  endtask

  // FIFO model: pop decision taken at the edge, queue updated just after it.
  always @(posedge clk) begin
    bit pop_s;
    pop_s = o_fifo_renable;
    #1;
    if (pop_s && fifo.size() > 0) begin
      void'(fifo.pop_front());
      pops++;
    end
    refresh();
  end

  // Monitor: record transfers, protocol observations.
  always @(negedge clk) begin
    logic [130:0] cur;
    cur = {o_vtx_x, o_vtx_y, o_vtx_z, o_vtx_w, o_vtx_idx, o_vtx_last};
    if (o_fifo_renable && (o_vtx_valid || i_fifo_empty)) bad_pop++;
    if (prev_wait && o_vtx_valid && cur !== prev_rec) unstable++;
    if (o_vtx_valid && i_vtx_ack) begin
      got_q.push_back(cur);
      acc_cyc.push_back(cyc);
    end
    if (o_vtx_valid && !i_vtx_ack) waits++;
    prev_wait = o_vtx_valid && !i_vtx_ack;
    prev_rec  = cur;
  end

  // ---------------- scoreboard check ----------------
  task automatic check(input string tag, input logic [130:0] obs, input logic [130:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Runs one job: builds its word stream, feeds it (preloaded or dripped),
  // drives ack, then compares records and end-of-job state with the model.
  task automatic run_job(input string tag, input int n, input bit seq_words,
                         input int drip, input int hold_rec, input int hold_cyc,
                         input bit rnd_ack, input bit hold_start, input bit chk_period);
    logic [31:0]  words[$];
    logic [130:0] exp_q[$];
    int need, pushed, held, pops0, waits0, cycles;
    bit finished;
    need = 3 * n * NW;
    for (int i = 0; i < need; i++) words.push_back(seq_words ? 32'(i + 1) : $urandom);
    for (int v = 0; v < 3 * n; v++) begin
      int b;
      logic [31:0] wv;
      logic [1:0] ix;
      logic lst;
      b   = v * NW;
      wv  = (NW == 4) ? words[b + NW - 1] : ONE;
      ix  = 2'(v % 3);
      lst = (v == 3 * n - 1);
      exp_q.push_back({words[b], words[b + 1], words[b + 2], wv, ix, lst});
    end
    got_q.delete();
    acc_cyc.delete();
    pops0  = pops;
    waits0 = waits;
    held   = 0;
    pushed = 0;
    finished = 1'b0;

    @(posedge clk); #2;
    if (drip == 0) begin
      foreach (words[i]) push_word(words[i]);
      pushed = need;
    end
    @(posedge clk); #1;
    i_start = 1'b1;
    i_num_tri = CNT_W'(n);
    @(posedge clk); #1;
    if (hold_start) i_num_tri = CNT_W'($urandom);
    else i_start = 1'b0;
    check({tag, ":start"}, {o_busy, o_tri_count}, {1'b1, {CNT_W{1'b0}}});

    for (cycles = 0; cycles < 4000 && !finished; cycles++) begin
      if (o_vtx_valid && got_q.size() == hold_rec && held < hold_cyc) begin
        i_vtx_ack = 1'b0;
        held++;
      end else begin
        i_vtx_ack = rnd_ack ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      #1;
      if (drip > 0 && pushed < need && (cycles % drip) == 0) begin
        push_word(words[pushed]);
        pushed++;
      end
      @(posedge clk); #1;
      if (o_done) begin
        finished = 1'b1;
        i_start  = 1'b0;
      end
    end

    check({tag, ":finished"}, 131'(finished), 131'(1));
    check({tag, ":busy_at_done"}, 131'(o_busy), 131'(0));
    check({tag, ":tri_count"}, 131'(o_tri_count), 131'(n));
    @(posedge clk); #1;
    check({tag, ":done_single"}, {o_done, o_busy}, 131'(0));
    check({tag, ":n_records"}, 131'(got_q.size()), 131'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s:rec%0d", tag, i), got_q[i], exp_q[i]);
    check({tag, ":fifo_drained"}, 131'(fifo.size()), 131'(0));
    check({tag, ":pops"}, 131'(pops - pops0), 131'(need));
    if (!rnd_ack) check({tag, ":wait_cycles"}, 131'(waits - waits0), 131'(hold_cyc));
    if (chk_period)
      for (int i = 1; i < acc_cyc.size(); i++)
        check($sformatf("%s:period%0d", tag, i), 131'(acc_cyc[i] - acc_cyc[i - 1]), 131'(NW + 1));
    i_vtx_ack = 1'b1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ":ctl"}, {o_vtx_valid, o_vtx_idx, o_vtx_last, o_busy, o_done, o_fifo_renable},
          131'(0));
    check({tag, ":tri"}, 131'(o_tri_count), 131'(0));
    check({tag, ":data"}, {o_vtx_x, o_vtx_y, o_vtx_z, o_vtx_w}, {96'h0, RST_W});
  endtask

  // ---------------- sequence ----------------
  initial begin
    int pops0;
    // reset
    repeat (3) @(posedge clk);
    #3;
    check_reset_values("reset");
    rst_x = 1'b1;
    @(posedge clk); #1;
    check_reset_values("post_reset_idle");

    // sequential words, preloaded, ack tied high
    run_job("seq", 1, 1'b1, 0, -1, 0, 1'b0, 1'b0, 1'b1);

    // drip-fed FIFO, one word every 3 cycles
    run_job("drip", 2, 1'b0, 3, -1, 0, 1'b0, 1'b0, 1'b0);

    // ack withheld 5 cycles on the second record, FIFO non-empty meanwhile
    run_job("hold", 1, 1'b0, 0, 1, 5, 1'b0, 1'b0, 1'b0);

    // zero-triangle job
    pops0 = pops;
    @(posedge clk); #1;
    i_start = 1'b1;
    i_num_tri = '0;
    @(posedge clk); #1;
    i_start = 1'b0;
    check("zero:done", {o_done, o_busy, o_tri_count}, {1'b1, 1'b0, {CNT_W{1'b0}}});
    @(posedge clk); #1;
    check("zero:after", {o_done, o_busy}, 131'(0));
    check("zero:pops", 131'(pops - pops0), 131'(0));

    // reset in the middle of FETCH
    @(posedge clk); #2;
    push_word($urandom);
    push_word($urandom);
    @(posedge clk); #1;
    i_start = 1'b1;
    i_num_tri = 16'd2;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    push_word($urandom);
    #1;
    check("midrst:before", {o_busy, o_fifo_renable, o_vtx_valid}, {1'b1, 1'b1, 1'b0});
    rst_x = 1'b0;
    #1;
    check_reset_values("midrst");
    fifo.delete();
    refresh();
    repeat (2) @(posedge clk);
    #3;
    rst_x = 1'b1;
    run_job("after_rst", 1, 1'b0, 0, -1, 0, 1'b0, 1'b0, 1'b0);

    // randomized jobs: random size, feed rate and ack; i_start held high
    for (int j = 0; j < 4; j++)
      run_job($sformatf("rnd%0d", j), $urandom_range(1, 3), 1'b0, $urandom_range(0, 2),
              -1, 0, 1'b1, 1'b1, 1'b0);

    check("no_bad_pop", 131'(bad_pop), 131'(0));
    check("stable_while_waiting", 131'(unstable), 131'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, observed no end, expected summary");
    $fatal(1, "watchdog");
  end

endmodule
